// File: rtl/uart_rx_d.sv
// uart_rx_d: 8E1 UART receiver with oversampled mid-bit sampling and error flags
module uart_rx_d #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       active_flag
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state, state_n;
  logic rx_meta, rxs, rxs_q;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] samp_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic par, tick, mid, full, start_go, false_start, done;
  assign tick        = tick_cnt == TW'(DIV - 1);
  assign mid         = tick && samp_cnt == SW'(OVERSAMPLE / 2 - 1);
  assign full        = tick && samp_cnt == SW'(OVERSAMPLE - 1);
  assign start_go    = state == IDLE && rxs_q && !rxs;
  assign false_start = state == START && mid && rxs;
  assign done        = state == STOP && full;
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next-state: start edge, mid-start validation, bit walk, break hold-off
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_go ? START : IDLE;
      START:   state_n = mid ? (rxs ? IDLE : DATA) : START;
      DATA:    state_n = full && bit_cnt == 3'd7 ? PARITY : DATA;
      PARITY:  state_n = full ? STOP : PARITY;
      STOP:    state_n = full ? (rxs ? IDLE : BREAK) : STOP;
      BREAK:   state_n = rxs ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
  end
  // synchroniser, tick divider, sample/bit counters, shift register and outputs
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rx_meta       <= 1'b1;
      rxs           <= 1'b1;
      rxs_q         <= 1'b1;
      tick_cnt      <= '0;
      samp_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par           <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      active_flag   <= 1'b0;
    end else begin
      rx_meta     <= data_rx;
      rxs         <= rx_meta;
      rxs_q       <= rxs;
      tick_cnt    <= start_go || tick ? '0 : tick_cnt + 1'b1;
      samp_cnt    <= start_go || (state == START ? mid : full) ? '0 : samp_cnt + SW'(tick);
      bit_cnt     <= state == START ? '0 : state == DATA && full ? bit_cnt + 3'd1 : bit_cnt;
      shreg       <= state == DATA && full ? {rxs, shreg[7:1]} : shreg;
      par         <= state == PARITY && full ? rxs : par;
      rx_valid    <= done;
      active_flag <= start_go ? 1'b1 : done || false_start ? 1'b0 : active_flag;
      if (done) begin
        rx_data       <= shreg;
        parity_error  <= par ^ (^shreg);
        framing_error <= ~rxs;
      end
    end
endmodule

// File: tb/tb_uart_rx_d.sv
// tb_uart_rx_d: table-driven and scoreboard checks of the UART receiver
module tb_uart_rx_d;
  logic clock = 1'b0, reset = 1'b1, data_rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, parity_error, framing_error, active_flag;
  uart_rx_d #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16)) dut (
    .clock(clock), .reset(reset), .data_rx(data_rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_error(parity_error), .framing_error(framing_error), .active_flag(active_flag)
  );
  always #5 clock = ~clock;
  typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
  typedef struct {logic [7:0] d; logic flip; logic stop; int hold; logic exp_pe; logic exp_fe;} vec_t;
  exp_t exp_q[$];
  vec_t vt[6];
  logic [7:0] rec_d[0:255];
  logic rec_pe[0:255], rec_fe[0:255];
  int vcount = 0;
  int checks = 0, errors = 0, idx = 0;
  // monitor: record every valid pulse seen on the output
  always @(negedge clock)
    if (rx_valid && vcount < 256) begin
      rec_d[vcount] = rx_data;
      rec_pe[vcount] = parity_error;
      rec_fe[vcount] = framing_error;
      vcount++;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop, input int hold, input logic chk_act);
    logic [10:0] bits;
    logic act_ok;
    bits = {stop, pbit, d, 1'b0};
    act_ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      data_rx = bits[i];
      repeat (8) @(negedge clock);
      if (!active_flag) act_ok = 1'b0;
      repeat (8) @(negedge clock);
    end
    if (hold > 0) begin
      data_rx = 1'b0;
      repeat (hold) @(negedge clock);
    end
    data_rx = 1'b1;
    if (chk_act) chk("active_during_frame", 32'(act_ok), 32'd1);
  endtask
  task automatic expect_frame(input string name);
    exp_t e;
    int n;
    n = 0;
    #1;
    while (vcount <= idx && n < 400) begin
      @(negedge clock);
      #1;
      n++;
    end
    e = exp_q.pop_front();
    chk({name, "_arrived"}, 32'(vcount > idx), 32'd1);
    if (vcount > idx) begin
      chk({name, "_data"}, 32'(rec_d[idx]), 32'(e.d));
      chk({name, "_parity_error"}, 32'(rec_pe[idx]), 32'(e.pe));
      chk({name, "_framing_error"}, 32'(rec_fe[idx]), 32'(e.fe));
      idx++;
    end
  endtask
  initial begin
    logic [7:0] r;
    logic [10:0] bits;
    vt[0] = '{8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vt[1] = '{8'h01, 1'b1, 1'b1, 0, 1'b1, 1'b0};
    vt[2] = '{8'h3C, 1'b0, 1'b0, 40, 1'b0, 1'b1};
    vt[3] = '{8'h55, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vt[4] = '{8'h80, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vt[5] = '{8'hC3, 1'b1, 1'b0, 0, 1'b1, 1'b1};
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    chk("reset_parity_error", 32'(parity_error), 32'h0);
    chk("reset_framing_error", 32'(framing_error), 32'h0);
    chk("reset_active_flag", 32'(active_flag), 32'h0);
    repeat (500) @(negedge clock);
    #1;
    chk("idle_no_valid", 32'(vcount), 32'(idx));
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vt[i].d, vt[i].exp_pe, vt[i].exp_fe});
      send_frame(vt[i].d, (^vt[i].d) ^ vt[i].flip, vt[i].stop, vt[i].hold, 1'b1);
      repeat (20) @(negedge clock);
      expect_frame($sformatf("vec%0d", i));
    end
    data_rx = 1'b0;
    repeat (4) @(negedge clock);
    chk("glitch_active_rise", 32'(active_flag), 32'd1);
    repeat (1) @(negedge clock);
    data_rx = 1'b1;
    repeat (10) @(negedge clock);
    chk("glitch_active_fall", 32'(active_flag), 32'd0);
    repeat (200) @(negedge clock);
    #1;
    chk("glitch_no_valid", 32'(vcount), 32'(idx));
    exp_q.push_back({8'h00, 1'b0, 1'b0});
    exp_q.push_back({8'hFF, 1'b0, 1'b0});
    send_frame(8'h00, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 0, 1'b1);
    repeat (20) @(negedge clock);
    expect_frame("b2b_first");
    expect_frame("b2b_second");
    bits = {1'b1, ^8'h96, 8'h96, 1'b0};
    for (int i = 0; i < 5; i++) begin
      data_rx = bits[i];
      repeat (16) @(negedge clock);
    end
    data_rx = bits[5];
    repeat (8) @(negedge clock);
    reset = 1'b1;
    data_rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (200) @(negedge clock);
    #1;
    chk("midreset_no_valid", 32'(vcount), 32'(idx));
    chk("midreset_active", 32'(active_flag), 32'd0);
    chk("midreset_rx_data", 32'(rx_data), 32'h0);
    exp_q.push_back({8'h69, 1'b0, 1'b0});
    send_frame(8'h69, ^8'h69, 1'b1, 0, 1'b1);
    repeat (20) @(negedge clock);
    expect_frame("after_reset");
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom_range(0, 255));
      exp_q.push_back({r, 1'b0, 1'b0});
      send_frame(r, ^r, 1'b1, 0, 1'b0);
      repeat (20) @(negedge clock);
      expect_frame($sformatf("rand%0d", i));
    end
    repeat (50) @(negedge clock);
    #1;
    chk("valid_count", 32'(vcount), 32'(idx));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
